// File: rtl/pwm_pkg.sv
// Shared timer definitions: config select codes, default widths
// and the select-to-channel mapping used by the PWM timers.
package pwm_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int RST_PERIOD_DEF = 332;
  localparam int SEL_PERIOD     = 0;

  // Duty selects start at 1; a negative or too-large result matches no channel.
  function automatic int sel_to_ch(input int sel);
    return sel - 1;
  endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: double-buffered duty register, the compare
// against the shared counter and the registered output.
module pwm_cmp_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] data,
  input  logic             xfer,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_shd;
  logic [CNT_W-1:0] duty_act;

  // Shadow duty takes config writes at any time.
  always_ff @(posedge clk) begin
    if (rst)     duty_shd <= '0;
    else if (wr) duty_shd <= data;
  end

  // Active duty only changes on a committed wrap, using the pre-write shadow.
  always_ff @(posedge clk) begin
    if (rst)       duty_act <= '0;
    else if (xfer) duty_act <= duty_shd;
  end

  // Registered compare; frozen while the counter is disabled.
  always_ff @(posedge clk) begin
    if (rst)     pwm <= 1'b0;
    else if (en) pwm <= (cnt < duty_act);
  end

endmodule

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: shared period counter, glitch-free
// double-buffered period/duty updates and a wrap-toggled divider.
module pwm_timer_multi
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int N_CH       = 4,
  parameter int RST_PERIOD = RST_PERIOD_DEF,
  parameter int SEL_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic [N_CH-1:0]  pwm_out,
  output logic             div_out,
  output logic             wrap,
  output logic             upd_pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_act;
  logic [CNT_W-1:0] per_shd;
  logic             at_top;
  logic             wrap_now;
  logic             xfer;
  logic             per_we;

  assign at_top   = (cnt == per_act);
  assign wrap_now = en && at_top;
  assign xfer     = wrap_now && upd_pending;
  assign per_we   = cfg_wr && (cfg_sel == SEL_W'(SEL_PERIOD));

  // Period counter: wraps to 0 after per_act, holds when disabled.
  always_ff @(posedge clk) begin
    if (rst)           cnt <= '0;
    else if (wrap_now) cnt <= '0;
    else if (en)       cnt <= cnt + CNT_W'(1);
  end

  // Wrap pulse and the divided clock that toggles on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap    <= 1'b0;
      div_out <= 1'b0;
    end else begin
      wrap <= wrap_now;
      if (wrap_now) div_out <= ~div_out;
    end
  end

  // Period shadow register, written by config at any time.
  always_ff @(posedge clk) begin
    if (rst)         per_shd <= CNT_W'(RST_PERIOD);
    else if (per_we) per_shd <= cfg_data;
  end

  // Active period only changes on a committed wrap.
  always_ff @(posedge clk) begin
    if (rst)       per_act <= CNT_W'(RST_PERIOD);
    else if (xfer) per_act <= per_shd;
  end

  // Commit arms the transfer; a commit on a wrap cycle waits for the next wrap.
  always_ff @(posedge clk) begin
    if (rst)             upd_pending <= 1'b0;
    else if (cfg_commit) upd_pending <= 1'b1;
    else if (xfer)       upd_pending <= 1'b0;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic we;

    assign we = cfg_wr && (sel_to_ch(int'(cfg_sel)) == i);

    pwm_cmp_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .wr   (we),
      .data (cfg_data),
      .xfer (xfer),
      .cnt  (cnt),
      .pwm  (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Directed bench for pwm_timer_multi: reset defaults, duty compare,
// double-buffered updates, enable freeze and reset discard.
module tb_pwm_timer_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_wr;
  logic [3:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        cfg_commit;
  logic [3:0]  pwm_out;
  logic        div_out;
  logic        wrap;
  logic        upd_pending;

  int checks = 0;
  int fails  = 0;
  int n;
  int hi [4];
  int nw;
  logic [3:0] acc;

  always #5 clk = ~clk;

  pwm_timer_multi dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .pwm_out     (pwm_out),
    .div_out     (div_out),
    .wrap        (wrap),
    .upd_pending (upd_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] sel, input logic [15:0] d);
    cfg_wr   = 1'b1;
    cfg_sel  = sel;
    cfg_data = d;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_wrap(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!wrap && k < 2000);
    if (!wrap) k = -1;
  endtask

  task automatic wait_div(input logic lvl, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (div_out !== lvl && k < 2000);
    if (div_out !== lvl) k = -1;
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    cfg_wr     = 1'b0;
    cfg_sel    = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    tick();
    tick();
    chk("rst_outs", {28'd0, pwm_out}, 32'd0);
    chk("rst_flags", {29'd0, div_out, wrap, upd_pending}, 32'd0);

    // 1: default period 333
    rst = 1'b0;
    en  = 1'b1;
    wait_div(1'b1, n);
    chk("t1_first_rise", n, 333);
    chk("t1_pwm_low", {28'd0, pwm_out}, 32'd0);
    wait_div(1'b0, n);
    chk("t1_toggle", n, 333);

    // 2: period 9, duties 3/0/10/5
    cfg(4'd0, 16'd9);
    cfg(4'd1, 16'd3);
    cfg(4'd2, 16'd0);
    cfg(4'd3, 16'd10);
    cfg(4'd4, 16'd5);
    commit();
    chk("t2_pending", {31'd0, upd_pending}, 32'd1);
    wait_wrap(n);
    chk("t2_applied", {31'd0, upd_pending}, 32'd0);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    nw = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
      nw += int'(wrap);
    end
    chk("t2_ch0_hi", hi[0], 3);
    chk("t2_ch1_hi", hi[1], 0);
    chk("t2_ch2_hi", hi[2], 10);
    chk("t2_ch3_hi", hi[3], 5);
    chk("t2_wraps", nw, 1);
    chk("t2_wrap_end", {31'd0, wrap}, 32'd1);

    // 3: period 4 committed mid-period
    tick();
    tick();
    cfg(4'd0, 16'd4);
    commit();
    chk("t3_pending", {31'd0, upd_pending}, 32'd1);
    wait_wrap(n);
    chk("t3_old_period", n, 6);
    chk("t3_applied", {31'd0, upd_pending}, 32'd0);
    wait_wrap(n);
    chk("t3_new_period_a", n, 5);
    wait_wrap(n);
    chk("t3_new_period_b", n, 5);

    // 4: commit on the wrap cycle
    cfg(4'd0, 16'd7);
    tick();
    tick();
    tick();
    commit();
    chk("t4_wrap", {31'd0, wrap}, 32'd1);
    chk("t4_pending_held", {31'd0, upd_pending}, 32'd1);
    for (int e = 0; e < 4; e++) tick();
    chk("t4_still_pending", {30'd0, wrap, upd_pending}, 32'd1);
    tick();
    chk("t4_late_apply", {30'd0, wrap, upd_pending}, 32'd2);
    wait_wrap(n);
    chk("t4_period8", n, 8);

    // 5: enable low for 7 cycles at cnt=3
    tick();
    tick();
    tick();
    chk("t5_pre", {26'd0, wrap, div_out, pwm_out}, 32'h0D);
    en = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      chk("t5_frozen", {26'd0, wrap, div_out, pwm_out}, 32'h0D);
    end
    en = 1'b1;
    tick();
    chk("t5_resume", {26'd0, wrap, div_out, pwm_out}, 32'h0C);
    wait_wrap(n);
    chk("t5_rest", n, 4);
    chk("t5_div", {31'd0, div_out}, 32'd1);

    // 6: reset with pending update, then invalid select
    cfg(4'd1, 16'd7);
    commit();
    tick();
    tick();
    tick();
    chk("t6_pending", {31'd0, upd_pending}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_outs", {28'd0, pwm_out}, 32'd0);
    chk("t6_rst_flags", {29'd0, div_out, wrap, upd_pending}, 32'd0);
    cfg(4'd5, 16'd1);
    commit();
    wait_wrap(n);
    chk("t6_rst_period", n, 331);
    chk("t6_applied", {31'd0, upd_pending}, 32'd0);
    acc = '0;
    for (int e = 0; e < 10; e++) begin
      tick();
      acc |= pwm_out;
    end
    chk("t6_duty_lost", {28'd0, acc}, 32'd0);
    wait_wrap(n);
    chk("t6_period_kept", n, 323);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
